// File: rtl/ram_pkg.sv
// Shared types and constants for the parametrised synchronous RAM.
// Also provides the storage-array address width for a given depth.
package ram_pkg;

    typedef enum logic {
        ESTADO_LIMPIANDO = 1'b0,
        ESTADO_ACTIVO    = 1'b1
    } estado_t;

    localparam logic LEER     = 1'b0;
    localparam logic ESCRIBIR = 1'b1;

    // Narrowest index that covers every word; a single-word array still needs one bit.
    function automatic int ancho_dir_mem(input int profundidad);
        return (profundidad > 1) ? $clog2(profundidad) : 1;
    endfunction

endpackage

// File: rtl/ram_nucleo.sv
// Raw storage array: one synchronous write port and one enabled, registered read port.
// Reads return the word held before a same-edge write to the same address.
module ram_nucleo #(
    parameter int ANCHO_DATO    = 8,
    parameter int PROFUNDIDAD   = 256,
    parameter int ANCHO_DIR_MEM = 8
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [ANCHO_DIR_MEM-1:0] dir_w,
    input  logic [ANCHO_DATO-1:0]    dato_w,
    input  logic                     re,
    input  logic [ANCHO_DIR_MEM-1:0] dir_r,
    output logic [ANCHO_DATO-1:0]    dato_r
);

    logic [ANCHO_DATO-1:0] mem_q [PROFUNDIDAD];
    logic [ANCHO_DATO-1:0] dato_r_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[dir_w] <= dato_w;
        end
        if (re) begin
            dato_r_q <= mem_q[dir_r];
        end
    end

    assign dato_r = dato_r_q;

endmodule

// File: rtl/ram_sincrona_param.sv
// Single-port synchronous RAM with request handshake, registered read data and a
// clear sequencer that fills every word with VALOR_INIT after reset or on limpiar.
module ram_sincrona_param
    import ram_pkg::*;
#(
    parameter int                    ANCHO_DATO  = 8,
    parameter int                    ANCHO_DIR   = 8,
    parameter int                    PROFUNDIDAD = 256,
    parameter logic [ANCHO_DATO-1:0] VALOR_INIT  = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  limpiar,
    input  logic                  solicitud,
    input  logic                  EN,
    input  logic [ANCHO_DIR-1:0]  direccion,
    input  logic [ANCHO_DATO-1:0] dato_e,
    output logic                  listo,
    output logic [ANCHO_DATO-1:0] dato_s,
    output logic                  dato_s_valido,
    output logic                  fuera_rango
);

    localparam int AW       = ancho_dir_mem(PROFUNDIDAD);
    localparam int ULT_INT  = PROFUNDIDAD - 1;
    localparam int PROF_INT = PROFUNDIDAD;
    localparam logic [ANCHO_DIR:0] ULTIMA = ULT_INT[ANCHO_DIR:0];
    localparam logic [ANCHO_DIR:0] LIMITE = PROF_INT[ANCHO_DIR:0];

    estado_t estado_q, estado_d;
    logic [ANCHO_DIR:0] contador_q, contador_d;

    logic valido_q, valido_d;
    logic fuera_q, fuera_d;
    logic cero_q, cero_d;

    logic acepta;
    logic lectura;
    logic en_rango;

    logic                  we_mem;
    logic                  re_mem;
    logic [AW-1:0]         dir_w_mem;
    logic [ANCHO_DATO-1:0] dato_w_mem;
    logic [ANCHO_DATO-1:0] dato_r_mem;

    assign acepta   = solicitud && (estado_q == ESTADO_ACTIVO) && !limpiar;
    assign lectura  = acepta && (EN == LEER);
    assign en_rango = ({1'b0, direccion} < LIMITE);

    always_ff @(posedge clk) begin
        if (rst) begin
            estado_q   <= ESTADO_LIMPIANDO;
            contador_q <= '0;
        end else begin
            estado_q   <= estado_d;
            contador_q <= contador_d;
        end
    end

    always_comb begin
        estado_d   = estado_q;
        contador_d = contador_q;
        case (estado_q)
            ESTADO_LIMPIANDO: begin
                contador_d = contador_q + (ANCHO_DIR + 1)'(1);
                if (contador_q == ULTIMA) begin
                    estado_d = ESTADO_ACTIVO;
                end
            end
            ESTADO_ACTIVO: begin
                if (limpiar) begin
                    estado_d   = ESTADO_LIMPIANDO;
                    contador_d = '0;
                end
            end
            default: begin
                estado_d   = ESTADO_LIMPIANDO;
                contador_d = '0;
            end
        endcase
    end

    // The clear sequencer owns the write port for the whole LIMPIANDO phase.
    always_comb begin
        listo      = 1'b0;
        we_mem     = 1'b0;
        re_mem     = 1'b0;
        dir_w_mem  = direccion[AW-1:0];
        dato_w_mem = dato_e;
        case (estado_q)
            ESTADO_LIMPIANDO: begin
                we_mem     = 1'b1;
                dir_w_mem  = contador_q[AW-1:0];
                dato_w_mem = VALOR_INIT;
            end
            ESTADO_ACTIVO: begin
                listo  = 1'b1;
                we_mem = acepta && (EN == ESCRIBIR) && en_rango;
                re_mem = lectura && en_rango;
            end
            default: begin
                listo = 1'b0;
            end
        endcase
    end

    ram_nucleo #(
        .ANCHO_DATO    (ANCHO_DATO),
        .PROFUNDIDAD   (PROFUNDIDAD),
        .ANCHO_DIR_MEM (AW)
    ) u_nucleo (
        .clk    (clk),
        .we     (we_mem),
        .dir_w  (dir_w_mem),
        .dato_w (dato_w_mem),
        .re     (re_mem),
        .dir_r  (direccion[AW-1:0]),
        .dato_r (dato_r_mem)
    );

    // cero_q masks the array output so reset and out-of-range reads present zero
    // without resetting or writing the storage register itself.
    always_comb begin
        valido_d = lectura;
        fuera_d  = acepta && !en_rango;
        cero_d   = cero_q;
        if (lectura) begin
            cero_d = !en_rango;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valido_q <= 1'b0;
            fuera_q  <= 1'b0;
            cero_q   <= 1'b1;
        end else begin
            valido_q <= valido_d;
            fuera_q  <= fuera_d;
            cero_q   <= cero_d;
        end
    end

    assign dato_s        = cero_q ? '0 : dato_r_mem;
    assign dato_s_valido = valido_q;
    assign fuera_rango   = fuera_q;

endmodule

// File: tb/tb_ram_sincrona_param.sv
// Directed bench for ram_sincrona_param: depth-256 and depth-200 instances, a reference
// memory model and a queue of expected per-cycle outputs checked one cycle after each step.
module tb_ram_sincrona_param;

    localparam logic LEER     = 1'b0;
    localparam logic ESCRIBIR = 1'b1;

    logic       clk;
    logic       rst;
    logic       lim  [2];
    logic       sol  [2];
    logic       en   [2];
    logic [7:0] dir  [2];
    logic [7:0] de   [2];
    logic       listo[2];
    logic [7:0] ds   [2];
    logic       val  [2];
    logic       fr   [2];

    typedef struct {
        int         b;
        logic       listo;
        logic       valido;
        logic       fuera;
        logic [7:0] dato;
    } esp_t;

    esp_t       cola[$];
    logic       activo[2];
    logic [7:0] mem_m [2][256];
    logic [7:0] ult   [2];
    int         prof  [2];
    int         tests_run;
    int         fallos;

    ram_sincrona_param #(
        .ANCHO_DATO(8), .ANCHO_DIR(8), .PROFUNDIDAD(256), .VALOR_INIT(8'h00)
    ) dut_a (
        .clk(clk), .rst(rst), .limpiar(lim[0]), .solicitud(sol[0]), .EN(en[0]),
        .direccion(dir[0]), .dato_e(de[0]), .listo(listo[0]), .dato_s(ds[0]),
        .dato_s_valido(val[0]), .fuera_rango(fr[0])
    );

    ram_sincrona_param #(
        .ANCHO_DATO(8), .ANCHO_DIR(8), .PROFUNDIDAD(200), .VALOR_INIT(8'h00)
    ) dut_b (
        .clk(clk), .rst(rst), .limpiar(lim[1]), .solicitud(sol[1]), .EN(en[1]),
        .direccion(dir[1]), .dato_e(de[1]), .listo(listo[1]), .dato_s(ds[1]),
        .dato_s_valido(val[1]), .fuera_rango(fr[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            fallos++;
            $error("FAIL %s observed=%0d required=%0d", tag, obs, exp);
        end
    endtask

    task automatic comparar();
        esp_t e;
        if (cola.size() > 0) begin
            e = cola.pop_front();
            chk($sformatf("dut%0d listo", e.b),  32'(listo[e.b]), 32'(e.listo));
            chk($sformatf("dut%0d valido", e.b), 32'(val[e.b]),   32'(e.valido));
            chk($sformatf("dut%0d fuera", e.b),  32'(fr[e.b]),    32'(e.fuera));
            chk($sformatf("dut%0d dato_s", e.b), 32'(ds[e.b]),    32'(e.dato));
        end
    endtask

    task automatic borrar_modelo(input int b);
        for (int i = 0; i < 256; i++) mem_m[b][i] = 8'h00;
    endtask

    task automatic inactivo();
        for (int k = 0; k < 2; k++) begin
            sol[k] = 1'b0;
            lim[k] = 1'b0;
            en[k]  = 1'b0;
            dir[k] = 8'h00;
            de[k]  = 8'h00;
        end
    endtask

    // One cycle of stimulus: check the previous step's outputs, drive, predict, push.
    task automatic paso(input int b, input bit sol_v, input bit en_v, input int d,
                        input int v, input bit lim_v);
        esp_t e;
        bit   acepta;
        bit   oor;
        @(negedge clk);
        comparar();
        inactivo();
        sol[b] = sol_v;
        en[b]  = en_v;
        dir[b] = d[7:0];
        de[b]  = v[7:0];
        lim[b] = lim_v;
        acepta = activo[b] && sol_v && !lim_v;
        oor    = (d >= prof[b]);
        if (acepta && en_v && !oor) mem_m[b][d] = v[7:0];
        if (acepta && !en_v) ult[b] = oor ? 8'h00 : mem_m[b][d];
        if (activo[b] && lim_v) begin
            activo[b] = 1'b0;
            borrar_modelo(b);
        end
        $display("[TB] dut=%0d sol=%0b en=%0b dir=%0d dato_e=%0d limpiar=%0b", b, sol_v, en_v, d, v, lim_v);
        e.b      = b;
        e.listo  = activo[b];
        e.valido = acepta && !en_v;
        e.fuera  = acepta && oor;
        e.dato   = ult[b];
        cola.push_back(e);
    endtask

    task automatic drenar();
        @(negedge clk);
        comparar();
        inactivo();
    endtask

    // Counts negedges with listo low, starting at the current negedge.
    task automatic esperar(input int b, input int esperado, input string tag);
        int n;
        n = 0;
        while (listo[b] !== 1'b1 && n < 2000) begin
            n++;
            @(negedge clk);
        end
        chk(tag, 32'(n), 32'(esperado));
        activo[b] = 1'b1;
    endtask

    task automatic modelo_reset();
        for (int k = 0; k < 2; k++) begin
            activo[k] = 1'b0;
            ult[k]    = 8'h00;
            borrar_modelo(k);
        end
    endtask

    initial begin
        tests_run = 0;
        fallos    = 0;
        prof[0]   = 256;
        prof[1]   = 200;
        inactivo();
        modelo_reset();

        // Reset held two cycles, then clear must take exactly 256 cycles.
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset listo",  32'(listo[0]), 32'd0);
        chk("reset dato_s", 32'(ds[0]),    32'd0);
        chk("reset valido", 32'(val[0]),   32'd0);
        chk("reset fuera",  32'(fr[0]),    32'd0);
        chk("reset listo_b", 32'(listo[1]), 32'd0);
        rst = 1'b0;
        esperar(0, 256, "clear after reset");
        activo[1] = 1'b1;

        paso(0, 1, LEER, 10, 0, 0);
        drenar();

        // Back-to-back writes then back-to-back reads.
        paso(0, 1, ESCRIBIR, 9, 64, 0);
        paso(0, 1, ESCRIBIR, 3, 25, 0);
        paso(0, 1, ESCRIBIR, 0, 55, 0);
        paso(0, 1, ESCRIBIR, 8, 87, 0);
        paso(0, 1, ESCRIBIR, 10, 115, 0);
        paso(0, 1, LEER, 9, 0, 0);
        paso(0, 1, LEER, 3, 0, 0);
        paso(0, 1, LEER, 0, 0, 0);
        paso(0, 1, LEER, 8, 0, 0);
        paso(0, 1, LEER, 10, 0, 0);
        drenar();

        // Read-after-write, then an idle cycle to confirm dato_s holds.
        paso(0, 1, ESCRIBIR, 5, 8'hAA, 0);
        paso(0, 1, LEER, 5, 0, 0);
        paso(0, 0, LEER, 0, 0, 0);
        drenar();

        // Depth-200 instance: last valid word and out-of-range accesses.
        paso(1, 1, ESCRIBIR, 199, 99, 0);
        paso(1, 1, ESCRIBIR, 250, 99, 0);
        paso(1, 1, LEER, 199, 0, 0);
        paso(1, 1, LEER, 250, 0, 0);
        paso(1, 1, LEER, 200, 0, 0);
        paso(1, 1, LEER, 50, 0, 0);
        drenar();

        // limpiar together with a write: request dropped, dato_s held through clear.
        paso(0, 1, ESCRIBIR, 3, 77, 1);
        drenar();
        esperar(0, 256, "clear after limpiar");
        paso(0, 1, LEER, 3, 0, 0);
        paso(0, 1, LEER, 9, 0, 0);
        drenar();

        // Reset in the middle of a clear restarts the full sequence.
        paso(0, 0, LEER, 0, 0, 1);
        drenar();
        repeat (99) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        modelo_reset();
        esperar(0, 256, "clear after mid-clear reset");
        activo[1] = 1'b1;
        paso(0, 0, LEER, 0, 0, 0);
        paso(0, 1, ESCRIBIR, 7, 42, 0);
        paso(0, 1, LEER, 7, 0, 0);
        paso(0, 1, LEER, 10, 0, 0);
        paso(1, 1, LEER, 199, 0, 0);
        drenar();

        $display("[TB] %0d tests run, %0d failed", tests_run, fallos);
        $finish;
    end

endmodule
